// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
//   Parameterised binary-to-one-hot decoder with enable and registered output.
//   Used as the register-file write-select decoder: each output bit drives the
//   write enable of one register, so the word is registered to keep those
//   enables glitch-free and aligned to the clock.
//
//   The combinational decode is a tree of small enable-gated sub-decoders.
//   The top stage consumes one index bit (odd widths) or two (even widths).
//   Every following stage consumes two more bits, with one 2-to-4 decoder per
//   parent output. A disabled parent therefore forces all of its leaves low.
//
// Parameters
//   INPUT_WIDTH : index width (1..8); output width is 2**INPUT_WIDTH
//
// Ports
//   clk   : system clock, rising-edge active
//   reset : asynchronous active-high reset, clears out
//   en    : decode enable; 0 makes the next registered word all zeros
//   in    : binary index to decode
//   out   : registered one-hot (or all-zero) select word
// ---------------------------------------------------------------------------

// Enable-gated leaf decoder: BITS-bit select to 2**BITS one-hot outputs.
module dec_stage #(
    parameter int BITS = 2
) (
    input  logic                 en,
    input  logic [BITS-1:0]      sel,
    output logic [2**BITS-1:0]   y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

module decoder #(
    parameter int INPUT_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [INPUT_WIDTH-1:0]      in,
    output logic [2**INPUT_WIDTH-1:0]   out
);

    localparam int OUT_W      = 2**INPUT_WIDTH;
    // Odd widths start with a 1-to-2 stage so every later stage is 2-to-4.
    localparam int FIRST_BITS = (INPUT_WIDTH % 2 == 1) ? 1 : 2;
    localparam int NUM_STAGES = (INPUT_WIDTH - FIRST_BITS) / 2 + 1;

    logic [OUT_W-1:0] next;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : stg
        // CONS index bits (from the MSB down) are already decoded above this
        // stage, so it has 2**CONS parent enables and consumes B more bits.
        localparam int CONS  = (s == 0) ? 0 : FIRST_BITS + 2 * (s - 1);
        localparam int B     = (s == 0) ? FIRST_BITS : 2;
        localparam int NODES = 2**CONS;
        localparam int LEAF  = 2**B;

        logic [NODES-1:0]      parent;
        logic [NODES*LEAF-1:0] y;

        if (s == 0) begin : g_root
            assign parent = en;
        end else begin : g_inner
            assign parent = stg[s-1].y;
        end

        // Parent node i already encodes the upper CONS bits as value i, so
        // its child k lands at i*LEAF+k; at the last stage that equals in.
        for (genvar i = 0; i < NODES; i++) begin : node
            dec_stage #(
                .BITS (B)
            ) u_dec (
                .en  (parent[i]),
                .sel (in[INPUT_WIDTH-1-CONS -: B]),
                .y   (y[i*LEAF +: LEAF])
            );
        end
    end

    assign next = stg[NUM_STAGES-1].y;

    // Output register bank; reset clears it without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= next;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder
//   Self-checking bench for decoder with INPUT_WIDTH=5. It runs a table of
//   {en, in, expected} vectors, several hand-written multi-cycle sequences
//   (reset, latency, enable toggle, mid-cycle reset) and random stimulus.
//   The random stimulus is checked against a bit-by-bit reference model.
// ---------------------------------------------------------------------------
module tb_decoder;

    localparam int IW    = 5;
    localparam int OUT_W = 2**IW;

    logic             clk;
    logic             reset;
    logic             en;
    logic [IW-1:0]    in;
    logic [OUT_W-1:0] out;

    int checks;
    int passes;

    typedef struct {
        logic             en;
        logic [IW-1:0]    in;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    decoder #(
        .INPUT_WIDTH (IW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .out   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bit k is set only when enabled and k is the index.
    function automatic logic [OUT_W-1:0] refModel(input logic e, input int idx);
        logic [OUT_W-1:0] r;
        for (int k = 0; k < OUT_W; k++) begin
            r[k] = e && (k == idx);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] exp);
        checks++;
        if (out === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, out, exp);
        end
    endtask

    // Drive inputs on the falling edge, then step to just after the next
    // rising edge so the registered result can be sampled.
    task automatic applyStimulus(input logic e, input logic [IW-1:0] idx);
        @(negedge clk);
        en = e;
        in = idx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        in    = 5'd3;

        // Reset held with a live enable/index: out must stay zero.
        #1;
        checkOutput("reset_async", '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", '0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 32'h0000_0008);

        // Table: disabled sweep, enabled sweep and a few explicit values.
        for (int i = 0; i < OUT_W; i++) begin
            vecs.push_back('{en: 1'b0, in: IW'(i), exp: 32'h0});
        end
        for (int i = 0; i < OUT_W; i++) begin
            vecs.push_back('{en: 1'b1, in: IW'(i), exp: refModel(1'b1, i)});
        end
        vecs.push_back('{en: 1'b1, in: 5'd0,  exp: 32'h0000_0001});
        vecs.push_back('{en: 1'b1, in: 5'd31, exp: 32'h8000_0000});
        vecs.push_back('{en: 1'b0, in: 5'd31, exp: 32'h0000_0000});
        vecs.push_back('{en: 1'b1, in: 5'd17, exp: 32'h0002_0000});

        foreach (vecs[v]) begin
            applyStimulus(vecs[v].en, vecs[v].in);
            checkOutput($sformatf("table[%0d]", v), vecs[v].exp);
            if (vecs[v].en) begin
                checks++;
                if ($countones(out) == 1 && out[vecs[v].in] === 1'b1) begin
                    passes++;
                end else begin
                    $display("[TB] FAIL onehot[%0d]: got 0x%08h, expected bit %0d only",
                             v, out, vecs[v].in);
                end
            end
        end

        // Latency: a mid-cycle index change is invisible until the next edge.
        applyStimulus(1'b1, 5'd5);
        checkOutput("latency_before", 32'h0000_0020);
        #2;
        in = 5'd9;
        #1;
        checkOutput("latency_between", 32'h0000_0020);
        @(posedge clk);
        #1;
        checkOutput("latency_after", 32'h0000_0200);

        // Enable toggle.
        applyStimulus(1'b1, 5'd12);
        checkOutput("toggle_on", 32'h0000_1000);
        applyStimulus(1'b0, 5'd12);
        checkOutput("toggle_off", 32'h0);
        applyStimulus(1'b1, 5'd12);
        checkOutput("toggle_back", 32'h0000_1000);

        // Reset pulse between edges clears out before any clock edge.
        applyStimulus(1'b1, 5'd16);
        checkOutput("midreset_before", 32'h0001_0000);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_async", 32'h0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_released", 32'h0);
        @(posedge clk);
        #1;
        checkOutput("midreset_restore", 32'h0001_0000);

        // An edge while reset is high is ignored.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_edge_ignored", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_edge_recover", 32'h0001_0000);

        // Random stimulus against the reference model.
        for (int r = 0; r < 300; r++) begin
            logic          re;
            logic [IW-1:0] ri;
            re = ($urandom_range(0, 3) != 0);
            ri = IW'($urandom_range(0, OUT_W - 1));
            applyStimulus(re, ri);
            checkOutput($sformatf("random[%0d] en=%0b in=%0d", r, re, ri),
                        refModel(re, int'(ri)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
